// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;
    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;
endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle between a serial_adder and its requester.
interface serial_adder_if
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (output start, a, b, ci, input busy, done, sum, cout);
    modport slave  (input start, a, b, ci, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder cell, reused once per clock by serial_adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ ci;
    assign cout = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder plus a registered carry, LSB first.
//   state | meaning
//   IDLE  | waiting for start
//   SHIFT | adding one bit per clock, busy=1
//   DONE  | one-cycle done pulse; a start here is accepted
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic [WIDTH-2:0] sum_sr;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s, fa_cout;
    logic             last_bit, load;
    logic [WIDTH-1:0] sum_nxt;

    full_adder u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .ci   (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    assign last_bit = (state == SHIFT) && (cnt == CNT_LAST);
    assign load     = bus.start && (state != SHIFT);
    // New bit enters at the MSB so the LSB-first result lands aligned after WIDTH shifts.
    assign sum_nxt  = {fa_s, sum_sr};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = bus.start ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                a_sr  <= bus.a;
                b_sr  <= bus.b;
                carry <= bus.ci;
                cnt   <= '0;
            end else if (state == SHIFT) begin
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                carry  <= fa_cout;
                sum_sr <= sum_nxt[WIDTH-1:1];
                if (last_bit) begin
                    sum_q  <= sum_nxt;
                    cout_q <= fa_cout;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign bus.busy = (state == SHIFT);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: per-cycle reference model plus directed literal checks.
module tb_serial_adder;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(W)) sif ();

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif.slave)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: remaining busy cycles and the arithmetic result of the accepted request.
    int           left = 0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_sum = '0;
    logic         m_cout = 1'b0;
    logic [W:0]   pending = '0;
    bit           m_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            left   = 0;
            m_done = 1'b0;
            m_sum  = '0;
            m_cout = 1'b0;
        end else begin
            bit acc;
            acc = sif.start && (left == 0);
            m_done = 1'b0;
            if (left > 0) begin
                left--;
                if (left == 0) begin
                    m_done = 1'b1;
                    {m_cout, m_sum} = pending;
                end
            end
            if (acc) begin
                pending = {1'b0, sif.a} + {1'b0, sif.b} + {{W{1'b0}}, sif.ci};
                left = W;
            end
        end
        m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy", {31'd0, sif.busy}, {31'd0, left > 0});
            chk("done", {31'd0, sif.done}, {31'd0, m_done});
            chk("sum", {24'd0, sif.sum}, {24'd0, m_sum});
            chk("cout", {31'd0, sif.cout}, {31'd0, m_cout});
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        @(negedge clk);
        sif.start = 1'b1;
        sif.a = a;
        sif.b = b;
        sif.ci = ci;
        @(negedge clk);
        sif.start = 1'b0;
        sif.a = W'($urandom);
        sif.b = W'($urandom);
        sif.ci = 1'($urandom);
    endtask

    task automatic wait_done(output int busy_cycles);
        bit seen;
        seen = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (sif.done) begin
                seen = 1'b1;
                break;
            end
            if (sif.busy) busy_cycles++;
            @(negedge clk);
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: got no done expected done within 40 cycles at %0t", $time);
        end
    endtask

    task automatic op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ci, input logic [W-1:0] exp_sum, input logic exp_cout);
        int bc;
        issue(a, b, ci);
        wait_done(bc);
        chk({name, "_busy_cycles"}, bc, W);
        chk({name, "_sum"}, {24'd0, sif.sum}, {24'd0, exp_sum});
        chk({name, "_cout"}, {31'd0, sif.cout}, {31'd0, exp_cout});
        @(negedge clk);
        chk({name, "_done_pulse"}, {31'd0, sif.done}, 32'd0);
    endtask

    initial begin
        int bc;
        int nd;
        sif.start = 1'b0;
        sif.a = '0;
        sif.b = '0;
        sif.ci = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_busy", {31'd0, sif.busy}, 32'd0);
        chk("rst_done", {31'd0, sif.done}, 32'd0);
        chk("rst_sum", {24'd0, sif.sum}, 32'd0);
        chk("rst_cout", {31'd0, sif.cout}, 32'd0);

        op("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        op("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        op("ff_01_ci", 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1);
        op("a5_5a_ci", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
        op("3c_0f", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0);

        // Start during SHIFT must be ignored.
        issue(8'h10, 8'h20, 1'b0);
        @(negedge clk);
        sif.start = 1'b1;
        sif.a = 8'hFF;
        sif.b = 8'hFF;
        @(negedge clk);
        sif.start = 1'b0;
        wait_done(bc);
        chk("ign_sum", {24'd0, sif.sum}, 32'h30);
        chk("ign_cout", {31'd0, sif.cout}, 32'd0);
        nd = 0;
        repeat (12) begin
            @(negedge clk);
            if (sif.done) nd++;
        end
        chk("ign_single_done", nd, 0);

        // Reset in the middle of an addition.
        issue(8'h7F, 8'h01, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, sif.busy}, 32'd0);
        chk("abort_sum", {24'd0, sif.sum}, 32'd0);
        chk("abort_cout", {31'd0, sif.cout}, 32'd0);
        rst_n = 1'b1;
        nd = 0;
        repeat (12) begin
            @(negedge clk);
            if (sif.done) nd++;
        end
        chk("abort_no_done", nd, 0);
        op("post_abort", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0);

        // Back-to-back: new start in the DONE cycle.
        issue(8'h3C, 8'h0F, 1'b0);
        wait_done(bc);
        sif.start = 1'b1;
        sif.a = 8'h80;
        sif.b = 8'h80;
        sif.ci = 1'b0;
        @(negedge clk);
        sif.start = 1'b0;
        chk("b2b_busy", {31'd0, sif.busy}, 32'd1);
        chk("b2b_hold_sum", {24'd0, sif.sum}, 32'h4B);
        wait_done(bc);
        chk("b2b_busy_cycles", bc, W);
        chk("b2b_sum", {24'd0, sif.sum}, 32'h00);
        chk("b2b_cout", {31'd0, sif.cout}, 32'd1);

        // Random traffic with occasional resets, checked by the per-cycle model.
        repeat (3000) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 99) != 0);
            sif.start = ($urandom_range(0, 3) == 0);
            sif.a = W'($urandom);
            sif.b = W'($urandom);
            sif.ci = 1'($urandom);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sif.start = 1'b0;
        repeat (12) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial N-bit adder built around the existing single-bit full_adder cell plus a registered carry. It captures two operands and a carry-in on a start request, then adds LSB-first at one bit per clock. It reports the N-bit sum and carry-out with a one-cycle done pulse. It sits directly upstream of the adder datapath consumers and lets us reuse the full_adder stage sequentially instead of rippling N copies.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset, sampled on rising clk
start  input  1  request to begin an addition; accepted only when busy=0
a  input  WIDTH  operand A, sampled on the accepting edge
b  input  WIDTH  operand B, sampled on the accepting edge
ci  input  1  carry-in, sampled on the accepting edge
busy  output  1  high while an addition is in progress
done  output  1  one-cycle pulse; sum/cout valid from this cycle onward
sum  output  WIDTH  result bits; held until the next completion
cout  output  1  final carry-out; held until the next completion

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rst_n); the polarity and synchronicity are fixed.
- Reset (rst_n=0 at a rising edge): state=IDLE; busy=0, done=0, sum=0, cout=0; shift registers, carry register and bit counter cleared.
- States:
  - IDLE: busy=0, done=0.
  - SHIFT: busy=1, done=0.
  - DONE: busy=0, done=1, lasts exactly one cycle.
- IDLE/DONE -> SHIFT: on an edge with start=1:
  - load a_sr<=a, b_sr<=b, carry<=ci, cnt<=0.
  - A start sampled in the DONE cycle is accepted (back-to-back operation).
- SHIFT, each edge:
  - feed a_sr[0], b_sr[0] and carry into the full_adder instance.
  - shift the full_adder s output into the MSB of sum_sr; sum_sr shifts right.
  - carry<=full_adder cout; a_sr and b_sr shift right; cnt<=cnt+1.
- SHIFT -> DONE: on the edge where cnt==WIDTH-1 (the WIDTH-th bit edge):
  - sum<=final sum_sr value; cout<=final carry.
  - Both outputs update on this same edge.
- DONE -> IDLE: next edge, unless start=1, in which case DONE -> SHIFT.
- Latency: start accepted at edge t0 -> done=1 in the cycle after edge t0+WIDTH. busy=1 for exactly WIDTH cycles.
- start=1 while busy=1 is ignored; operands are not re-sampled and the in-flight result is unaffected.
- a, b and ci are don't-care except on the accepting edge.
- Arithmetic: {cout,sum} == a+b+ci, modulo 2^(WIDTH+1). No overflow flag.
- Reset mid-SHIFT: abort immediately, return to IDLE, no done pulse, sum/cout cleared to 0.
- rst_n=0 and start=1 on the same edge: reset wins.
- cnt width: $clog2(WIDTH). The counter never wraps, because the SHIFT -> DONE exit occurs at WIDTH-1.

Decomposition:
- Shared package serial_adder_pkg:
  - state enum typedef: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - constant DEFAULT_WIDTH=8.
- One sub-module: full_adder (existing cell, ports a, b, ci, s, cout), instantiated once and used combinationally in the SHIFT datapath.
- Counter, FSM and shift registers are kept in serial_adder itself.

Test Plan:
- WIDTH=8, reset 2 cycles then a=8'h00, b=8'h00, ci=0, start pulse -> busy=1 for 8 cycles, done=1 on 9th cycle after accept, sum=8'h00, cout=0.
- a=8'hFF, b=8'h01, ci=0 -> sum=8'h00, cout=1, done single-cycle. Same operands with ci=1 -> sum=8'h01, cout=1.
- a=8'hA5, b=8'h5A, ci=1 -> sum=8'h00, cout=1. a=8'h3C, b=8'h0F, ci=0 -> sum=8'h4B, cout=0.
- Start a=8'h10, b=8'h20, then pulse start with a=8'hFF, b=8'hFF in cycle 3 of SHIFT -> second start ignored, result sum=8'h30, cout=0, exactly one done.
- Start a=8'h7F, b=8'h01, drive rst_n=0 at cycle 4 of SHIFT -> next cycle busy=0, sum=0, cout=0, no done pulse. A new start after release completes normally.
- Back-to-back: hold start=1 in the DONE cycle with new operands 8'h80+8'h80, ci=0 -> busy re-asserts the next cycle, second done 9 cycles later, sum=8'h00, cout=1. First result stays visible until then.
